// File: rtl/turbo_deint_ctrl.sv
// Receive-side length/buffer controller for the turbo deinterleaver: counts LLR pairs into a
// ping-pong pair RAM and streams sequential pair indices of each filled bank to the decoder.
module turbo_deint_ctrl #(
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    pb_size,
    input  logic          din_vld,
    output logic          din_rdy,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          wr_bank,
    input  logic          rd_en,
    output logic          rd_vld,
    output logic [AW-1:0] rd_addr,
    output logic          rd_bank,
    output logic [AW-1:0] rd_len,
    output logic          rd_last,
    output logic          blk_done,
    output logic          err
);

    typedef enum logic [0:0] {RIdle, RRun} rd_state_e;

    function automatic logic [AW-1:0] pb_len(input logic [1:0] code);
        case (code)
            2'b00:   pb_len = AW'(64);
            2'b01:   pb_len = AW'(544);
            2'b10:   pb_len = AW'(2080);
            default: pb_len = '0;
        endcase
    endfunction

    // Write side state
    logic [AW-1:0] wcnt_q, wlen_q, len0_q, len1_q;
    logic          wbank_q, err_q;
    logic [1:0]    full_q, full_d, full_seen_q;

    // Read side state
    rd_state_e     state_q, state_d;
    logic          rbank_q, rbank_d;
    logic          rd_vld_q, rd_vld_d, rd_bank_q, rd_bank_d;
    logic          rd_last_q, rd_last_d, blk_done_q, blk_done_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d, rd_len_q, rd_len_d;
    logic          rd_release;

    logic          first, reserved, accept, wr_fire, wr_done;
    logic [AW-1:0] req_len, cur_len, sel_len;

    always_comb begin
        req_len  = pb_len(pb_size);
        first    = (wcnt_q == '0);
        reserved = first && (pb_size == 2'b11);
        accept   = din_vld && !full_q[wbank_q];
        wr_fire  = accept && !reserved;
        // The block length is only known from pb_size on the first pair.
        cur_len  = first ? req_len : wlen_q;
        wr_done  = wr_fire && (wcnt_q == cur_len - AW'(1));
    end

    // Write completion and read release always target different banks.
    always_comb begin
        full_d = full_q;
        if (wr_done) full_d[wbank_q] = 1'b1;
        if (rd_release) full_d[rbank_q] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_q      <= '0;
            wlen_q      <= '0;
            wbank_q     <= 1'b0;
            len0_q      <= '0;
            len1_q      <= '0;
            full_q      <= 2'b00;
            full_seen_q <= 2'b00;
            err_q       <= 1'b0;
        end else begin
            full_q      <= full_d;
            full_seen_q <= full_q;
            err_q       <= accept && reserved;
            if (wr_fire) begin
                if (first) wlen_q <= req_len;
                if (wr_done) begin
                    wcnt_q  <= '0;
                    wbank_q <= ~wbank_q;
                    if (wbank_q) len1_q <= cur_len;
                    else         len0_q <= cur_len;
                end else begin
                    wcnt_q <= wcnt_q + AW'(1);
                end
            end
        end
    end

    assign sel_len = rbank_q ? len1_q : len0_q;

    always_comb begin
        state_d    = state_q;
        rbank_d    = rbank_q;
        rd_vld_d   = rd_vld_q;
        rd_addr_d  = rd_addr_q;
        rd_bank_d  = rd_bank_q;
        rd_len_d   = rd_len_q;
        rd_last_d  = rd_last_q;
        blk_done_d = 1'b0;
        rd_release = 1'b0;
        case (state_q)
            RIdle: begin
                // Registered copy of full gives the two-cycle fill-to-valid latency.
                if (full_seen_q[rbank_q]) begin
                    rd_addr_d = '0;
                    rd_len_d  = sel_len;
                    rd_bank_d = rbank_q;
                    rd_last_d = 1'b0;
                    rd_vld_d  = 1'b1;
                    state_d   = RRun;
                end
            end
            RRun: begin
                if (rd_en) begin
                    if (rd_last_q) begin
                        rd_release = 1'b1;
                        rbank_d    = ~rbank_q;
                        blk_done_d = 1'b1;
                        rd_vld_d   = 1'b0;
                        rd_last_d  = 1'b0;
                        state_d    = RIdle;
                    end else begin
                        rd_addr_d = rd_addr_q + AW'(1);
                        rd_last_d = (rd_addr_q + AW'(1) == rd_len_q - AW'(1));
                    end
                end
            end
            default: state_d = RIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RIdle;
            rbank_q    <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_addr_q  <= '0;
            rd_bank_q  <= 1'b0;
            rd_len_q   <= '0;
            rd_last_q  <= 1'b0;
            blk_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rbank_q    <= rbank_d;
            rd_vld_q   <= rd_vld_d;
            rd_addr_q  <= rd_addr_d;
            rd_bank_q  <= rd_bank_d;
            rd_len_q   <= rd_len_d;
            rd_last_q  <= rd_last_d;
            blk_done_q <= blk_done_d;
        end
    end

    assign din_rdy  = !full_q[wbank_q];
    assign wr_en    = wr_fire;
    assign wr_addr  = wcnt_q;
    assign wr_bank  = wbank_q;
    assign rd_vld   = rd_vld_q;
    assign rd_addr  = rd_addr_q;
    assign rd_bank  = rd_bank_q;
    assign rd_len   = rd_len_q;
    assign rd_last  = rd_last_q;
    assign blk_done = blk_done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_turbo_deint_ctrl.sv
// Directed bench for turbo_deint_ctrl: a vector table for reset/reserved-size handling plus
// hand-written sequences for block fill, drain, stalls, both-banks-full and mid-block reset.
module tb_turbo_deint_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pb_size = 2'b00;
    logic        din_vld = 1'b0;
    logic        rd_en = 1'b0;
    logic        din_rdy, wr_en, wr_bank, rd_vld, rd_bank, rd_last, blk_done, err;
    logic [11:0] wr_addr, rd_addr, rd_len;

    int errors = 0;
    int checks = 0;

    turbo_deint_ctrl #(.AW(12)) dut (
        .clk      (clk),
        .rst      (rst),
        .pb_size  (pb_size),
        .din_vld  (din_vld),
        .din_rdy  (din_rdy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_bank  (wr_bank),
        .rd_en    (rd_en),
        .rd_vld   (rd_vld),
        .rd_addr  (rd_addr),
        .rd_bank  (rd_bank),
        .rd_len   (rd_len),
        .rd_last  (rd_last),
        .blk_done (blk_done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [1:0]  pb;
        logic        v;
        logic        re;
        logic        rdy;
        logic        wen;
        logic [11:0] waddr;
        logic        wbank;
        logic        rvld;
        logic [11:0] raddr;
        logic        rbank;
        logic [11:0] rlen;
        logic        rlast;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vt[6];
    vec_t rst_vec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs just after a falling edge, then let combinational outputs settle.
    task automatic drive(input logic r, input logic [1:0] pb, input logic v, input logic re);
        @(negedge clk);
        rst     = r;
        pb_size = pb;
        din_vld = v;
        rd_en   = re;
        #1;
    endtask

    task automatic check_out(input string tag, input vec_t e);
        chk({tag, ".din_rdy"},  32'(din_rdy),  32'(e.rdy));
        chk({tag, ".wr_en"},    32'(wr_en),    32'(e.wen));
        chk({tag, ".wr_addr"},  32'(wr_addr),  32'(e.waddr));
        chk({tag, ".wr_bank"},  32'(wr_bank),  32'(e.wbank));
        chk({tag, ".rd_vld"},   32'(rd_vld),   32'(e.rvld));
        chk({tag, ".rd_addr"},  32'(rd_addr),  32'(e.raddr));
        chk({tag, ".rd_bank"},  32'(rd_bank),  32'(e.rbank));
        chk({tag, ".rd_len"},   32'(rd_len),   32'(e.rlen));
        chk({tag, ".rd_last"},  32'(rd_last),  32'(e.rlast));
        chk({tag, ".blk_done"}, 32'(blk_done), 32'(e.done));
        chk({tag, ".err"},      32'(err),      32'(e.err));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int cyc;
        logic re;

        //          r     pb     v     re    rdy   wen   waddr  wb    rvld  raddr  rb    rlen   rl    dn    err
        vt[0] = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0};
        vt[2] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b1};
        vt[3] = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 12'd0, 1'b0, 1'b0, 12'd0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0};
        vt[4] = '{1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 12'd1, 1'b0, 1'b0, 12'd0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0};
        vt[5] = '{1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 12'd2, 1'b0, 1'b0, 12'd0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0};
        rst_vec = vt[0];

        // Reset, reserved size rejected, then a PB16 block whose size ignores later pb_size.
        for (int k = 0; k < 6; k++) begin
            drive(vt[k].r, vt[k].pb, vt[k].v, vt[k].re);
            check_out($sformatf("vec%0d", k), vt[k]);
        end

        for (int i = 2; i < 64; i++) begin
            drive(1'b0, 2'b00, 1'b1, 1'b1);
            chk("pb16.wr_addr", 32'(wr_addr), 32'(i));
            chk("pb16.wr_en",   32'(wr_en),   32'd1);
            chk("pb16.wr_bank", 32'(wr_bank), 32'd0);
        end
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        chk("pb16.bank_toggle", 32'(wr_bank), 32'd1);
        chk("pb16.vld_lat1",    32'(rd_vld),  32'd0);
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        chk("pb16.vld_lat2",    32'(rd_vld),  32'd0);
        for (int j = 0; j < 64; j++) begin
            drive(1'b0, 2'b00, 1'b0, 1'b1);
            chk("pb16.rd_vld",  32'(rd_vld),  32'd1);
            chk("pb16.rd_addr", 32'(rd_addr), 32'(j));
            chk("pb16.rd_last", 32'(rd_last), 32'(j == 63));
            chk("pb16.rd_bank", 32'(rd_bank), 32'd0);
            chk("pb16.rd_len",  32'(rd_len),  32'd64);
        end
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        chk("pb16.blk_done", 32'(blk_done), 32'd1);
        chk("pb16.vld_drop", 32'(rd_vld),   32'd0);
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        chk("pb16.done_pulse", 32'(blk_done), 32'd0);
        chk("pb16.idle",       32'(rd_vld),   32'd0);

        // PB520 then PB136 with the reader stalled: both banks fill, input back-pressured.
        drive(1'b1, 2'b00, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 2080; i++) begin
            drive(1'b0, 2'b10, 1'b1, 1'b0);
            chk("pb520.wr_addr", 32'(wr_addr), 32'(i));
            chk("pb520.wr_en",   32'(wr_en),   32'd1);
            chk("pb520.wr_bank", 32'(wr_bank), 32'd0);
        end
        for (int i = 0; i < 544; i++) begin
            drive(1'b0, 2'b01, 1'b1, 1'b0);
            chk("pb136.wr_addr", 32'(wr_addr), 32'(i));
            chk("pb136.wr_bank", 32'(wr_bank), 32'd1);
            chk("pb136.din_rdy", 32'(din_rdy), 32'd1);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 2'b00, 1'b1, 1'b0);
            chk("full.din_rdy", 32'(din_rdy), 32'd0);
            chk("full.wr_en",   32'(wr_en),   32'd0);
            chk("full.rd_vld",  32'(rd_vld),  32'd1);
            chk("full.rd_addr", 32'(rd_addr), 32'd0);
            chk("full.rd_len",  32'(rd_len),  32'd2080);
            chk("full.rd_bank", 32'(rd_bank), 32'd0);
        end
        for (int j = 0; j < 2080; j++) begin
            drive(1'b0, 2'b00, 1'b1, 1'b1);
            chk("rd520.rd_addr", 32'(rd_addr), 32'(j));
            chk("rd520.rd_last", 32'(rd_last), 32'(j == 2079));
            chk("rd520.wr_en",   32'(wr_en),   32'd0);
        end
        drive(1'b0, 2'b00, 1'b1, 1'b1);
        chk("resume.blk_done", 32'(blk_done), 32'd1);
        chk("resume.rd_vld",   32'(rd_vld),   32'd0);
        chk("resume.din_rdy",  32'(din_rdy),  32'd1);
        chk("resume.wr_en",    32'(wr_en),    32'd1);
        chk("resume.wr_addr",  32'(wr_addr),  32'd0);
        chk("resume.wr_bank",  32'(wr_bank),  32'd0);

        // Bank 1 drained with rd_en toggling every cycle.
        idx = 0;
        cyc = 0;
        while (idx < 544 && cyc < 2000) begin
            re = (cyc % 2 == 1);
            drive(1'b0, 2'b00, 1'b0, re);
            if (cyc == 0) chk("stall.wr_addr", 32'(wr_addr), 32'd1);
            chk("stall.rd_vld",  32'(rd_vld),  32'd1);
            chk("stall.rd_bank", 32'(rd_bank), 32'd1);
            chk("stall.rd_len",  32'(rd_len),  32'd544);
            chk("stall.rd_addr", 32'(rd_addr), 32'(idx));
            chk("stall.rd_last", 32'(rd_last), 32'(idx == 543));
            if (re) idx++;
            cyc++;
        end
        chk("stall.count", 32'(idx), 32'd544);
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        chk("stall.blk_done", 32'(blk_done), 32'd1);
        chk("stall.rd_vld",   32'(rd_vld),   32'd0);
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        chk("stall.partial_idle", 32'(rd_vld),  32'd0);
        chk("stall.done_pulse",   32'(blk_done), 32'd0);
        chk("stall.din_rdy",      32'(din_rdy),  32'd1);

        // Reset mid-write, then mid-read; each time the next block starts at bank 0, index 0.
        drive(1'b1, 2'b00, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) drive(1'b0, 2'b10, 1'b1, 1'b0);
        chk("mid.wr_addr_300", 32'(wr_addr), 32'd299);
        drive(1'b1, 2'b10, 1'b0, 1'b0);
        check_out("rst_wr", rst_vec);
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 2'b00, 1'b1, 1'b1);
            chk("post_rst.wr_addr", 32'(wr_addr), 32'(i));
            chk("post_rst.wr_bank", 32'(wr_bank), 32'd0);
        end
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        for (int j = 0; j < 5; j++) begin
            drive(1'b0, 2'b00, 1'b0, 1'b1);
            chk("mid_rd.rd_addr", 32'(rd_addr), 32'(j));
            chk("mid_rd.rd_vld",  32'(rd_vld),  32'd1);
        end
        drive(1'b1, 2'b00, 1'b0, 1'b1);
        check_out("rst_rd", rst_vec);
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 2'b00, 1'b1, 1'b0);
            chk("post_rst2.wr_addr", 32'(wr_addr), 32'(i));
            chk("post_rst2.wr_bank", 32'(wr_bank), 32'd0);
        end
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        chk("post_rst2.rd_vld0", 32'(rd_vld), 32'd0);
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        chk("post_rst2.rd_vld",  32'(rd_vld),  32'd1);
        chk("post_rst2.rd_bank", 32'(rd_bank), 32'd0);
        chk("post_rst2.rd_addr", 32'(rd_addr), 32'd0);
        chk("post_rst2.rd_len",  32'(rd_len),  32'd64);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
